dsec_in_packer: RTL and testbench

//  Packs the 32-bit word stream read from SDRAM (DQ width) into 64-bit blocks for the DSEC input port.

---
 rtl/dsec_in_packer.sv | 105 ++++++++++
 tb/tb_dsec_in_packer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dsec_in_packer.sv
// Packs pairs of 32-bit SDRAM read words into 64-bit blocks and queues them
// in a first-word-fall-through FIFO for the DSEC input port.
module dsec_in_packer #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   word_in,
  input  logic          word_valid,
  output logic          word_ready,
  input  logic          flush,
  input  logic          rdy,
  output logic          in_valid,
  output logic [63:0]   data_in,
  output logic [LW-1:0] fifo_level,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);

  // Handshakes: a word moves when word_valid && word_ready; a block moves
  // when in_valid && rdy. Neither ready depends on the matching valid.
  typedef enum logic {LO = 1'b0, HI = 1'b1} state_t;

  state_t        state, state_next;
  logic [31:0]   lo_reg;
  logic          flush_pend, flush_pend_next;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, accept, pop, push, load_lo;
  logic [63:0]   push_data;

  assign full       = (level == LW'(DEPTH));
  assign word_ready = !full;
  assign accept     = word_valid && word_ready;
  assign in_valid   = (level != '0);
  assign pop        = in_valid && rdy;
  assign data_in    = in_valid ? mem[rd_ptr] : 64'h0;
  assign fifo_level = level;
  assign busy       = (state == HI) || in_valid;

  always_comb begin
    state_next      = state;
    flush_pend_next = flush_pend;
    push            = 1'b0;
    push_data       = 64'h0;
    load_lo         = 1'b0;
    case (state)
      LO: begin
        flush_pend_next = 1'b0;
        if (accept) begin
          load_lo    = 1'b1;
          state_next = HI;
        end
      end
      HI: begin
        if (accept) begin
          push            = 1'b1;
          push_data       = {word_in, lo_reg};
          state_next      = LO;
          flush_pend_next = 1'b0;
        end else if (flush_pend && !full) begin
          // Pending half is emitted alone with a zero upper word.
          push            = 1'b1;
          push_data       = {32'h0, lo_reg};
          state_next      = LO;
          flush_pend_next = 1'b0;
        end else if (flush) begin
          flush_pend_next = 1'b1;
        end
      end
      default: state_next = LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LO;
      lo_reg     <= 32'h0;
      flush_pend <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
      if (load_lo) lo_reg <= word_in;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: data_in is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_dsec_in_packer.sv
// Bench for dsec_in_packer: directed scenarios plus randomized traffic checked
// against a queue-based model of word pairing, flushing and block delivery.
module tb_dsec_in_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   word_in = 32'h0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          flush = 1'b0;
  logic          rdy = 1'b0;
  logic          in_valid;
  logic [63:0]   data_in;
  logic [LW-1:0] fifo_level;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: blocks waiting in the FIFO plus the unpaired half word.
  logic [63:0] exp_q[$];
  logic        m_half_v = 1'b0;
  logic [31:0] m_half   = 32'h0;
  logic        m_fp     = 1'b0;

  dsec_in_packer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .flush(flush), .rdy(rdy), .in_valid(in_valid),
    .data_in(data_in), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    exp_q.delete();
    m_half_v = 1'b0;
    m_half   = 32'h0;
    m_fp     = 1'b0;
  endtask

  // Drive one cycle from a falling edge and advance the model at the rising edge.
  task automatic cycle(input logic wv, input logic [31:0] w, input logic fl, input logic r);
    logic room, acc;
    word_valid = wv; word_in = w; flush = fl; rdy = r;
    room = (exp_q.size() < DEPTH);
    acc  = wv && room;
    @(posedge clk);
    if (r && exp_q.size() != 0) void'(exp_q.pop_front());
    if (!m_half_v) begin
      if (acc) begin m_half = w; m_half_v = 1'b1; end
      m_fp = 1'b0;
    end else if (acc) begin
      exp_q.push_back({w, m_half}); m_half_v = 1'b0; m_fp = 1'b0;
    end else if (m_fp && room) begin
      exp_q.push_back({32'h0, m_half}); m_half_v = 1'b0; m_fp = 1'b0;
    end else if (fl) begin
      m_fp = 1'b1;
    end
    @(negedge clk);
    word_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; word_valid = 1'b0; flush = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid got %b exp 0", in_valid); end
    n_checks++; if (data_in !== 64'h0) begin n_fail++; $display("FAIL reset_data_in got %h exp 0", data_in); end
    n_checks++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_word_ready got %b exp 1", word_ready); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_checks++; if (word_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset got ready=%b busy=%b exp 1 0", word_ready, busy); end
  endtask

  task automatic test_basic_pack();
    cycle(1'b1, 32'h11111111, 1'b0, 1'b1);
    n_checks++; if (in_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_half got valid=%b busy=%b exp 0 1", in_valid, busy); end
    cycle(1'b1, 32'h22222222, 1'b0, 1'b1);
    n_checks++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", in_valid); end
    n_checks++; if (data_in !== 64'h22222222_11111111) begin n_fail++; $display("FAIL basic_data got %h exp 2222222211111111", data_in); end
    n_checks++; if (fifo_level !== LW'(1)) begin n_fail++; $display("FAIL basic_level got %0d exp 1", fifo_level); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (fifo_level !== '0 || in_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_drain got level=%0d valid=%b busy=%b exp 0 0 0", fifo_level, in_valid, busy); end
  endtask

  task automatic test_full_backpressure();
    logic [31:0] w [8];
    for (int i = 0; i < 8; i++) w[i] = 32'hA0000000 + 32'(i * 3 + 1);
    for (int i = 0; i < 8; i++) cycle(1'b1, w[i], 1'b0, 1'b0);
    n_checks++; if (fifo_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL full_level got %0d exp %0d", fifo_level, DEPTH); end
    n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL full_word_ready got %b exp 0", word_ready); end
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    n_checks++; if (fifo_level !== LW'(DEPTH) || data_in !== {w[1], w[0]}) begin n_fail++; $display("FAIL full_hold got level=%0d data=%h", fifo_level, data_in); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (data_in !== {w[2*i+1], w[2*i]}) begin n_fail++; $display("FAIL full_order%0d got %h exp %h", i, data_in, {w[2*i+1], w[2*i]}); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      if (i == 0) begin
        n_checks++; if (fifo_level !== LW'(3) || word_ready !== 1'b1) begin n_fail++; $display("FAIL full_first_pop got level=%0d ready=%b exp 3 1", fifo_level, word_ready); end
      end
    end
    n_checks++; if (fifo_level !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_extra_word got level=%0d busy=%b exp 0 0", fifo_level, busy); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'hABCDEF01, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (fifo_level !== LW'(1) || data_in !== 64'h00000000_ABCDEF01) begin n_fail++; $display("FAIL flush_block got level=%0d data=%h exp 1 00000000abcdef01", fifo_level, data_in); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b exp 1", busy); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %b exp 0", busy); end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (fifo_level !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_in_lo got level=%0d busy=%b exp 0 0", fifo_level, busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL stream_stall%0d got ready=%b exp 1", i, word_ready); end
      n_checks++; if (in_valid && exp_q.size() != 0 && data_in !== exp_q[0]) begin n_fail++; $display("FAIL stream_data%0d got %h exp %h", i, data_in, exp_q[0]); end
      cycle(1'b1, $urandom, 1'b0, 1'b1);
      n_checks++; if (fifo_level > LW'(1) || fifo_level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL stream_level%0d got %0d exp %0d", i, fifo_level, exp_q.size()); end
    end
    n_checks++; if (data_in !== exp_q[0]) begin n_fail++; $display("FAIL stream_last got %h exp %h", data_in, exp_q[0]); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h77770000 + 32'(i), 1'b0, 1'b0);
    n_checks++; if (fifo_level !== LW'(2) || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got level=%0d busy=%b exp 2 1", fifo_level, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_valid !== 1'b0 || data_in !== 64'h0) begin n_fail++; $display("FAIL midrst_out got valid=%b data=%h exp 0 0", in_valid, data_in); end
    n_checks++; if (fifo_level !== '0 || busy !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_status got level=%0d busy=%b ready=%b exp 0 0 1", fifo_level, busy, word_ready); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (in_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_nopartial got valid=%b busy=%b exp 0 0", in_valid, busy); end
    cycle(1'b1, 32'h55550001, 1'b0, 1'b0);
    cycle(1'b1, 32'h55550002, 1'b0, 1'b0);
    n_checks++; if (data_in !== 64'h55550002_55550001 || fifo_level !== LW'(1)) begin n_fail++; $display("FAIL midrst_repack got %h level=%0d exp 5555000255550001 1", data_in, fifo_level); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic wv, r, fl;
    for (int i = 0; i < 400; i++) begin
      n_checks++; if (in_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid%0d got %b exp %b", i, in_valid, exp_q.size() != 0); end
      n_checks++; if (data_in !== ((exp_q.size() != 0) ? exp_q[0] : 64'h0)) begin n_fail++; $display("FAIL rand_data%0d got %h", i, data_in); end
      n_checks++; if (fifo_level !== LW'(exp_q.size())) begin n_fail++; $display("FAIL rand_level%0d got %0d exp %0d", i, fifo_level, exp_q.size()); end
      n_checks++; if (word_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready%0d got %b", i, word_ready); end
      n_checks++; if (busy !== (m_half_v || exp_q.size() != 0)) begin n_fail++; $display("FAIL rand_busy%0d got %b exp %b", i, busy, m_half_v || exp_q.size() != 0); end
      wv = ($urandom_range(0, 3) != 0);
      r  = ((i / 40) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 9) == 0);
      cycle(wv, $urandom, fl, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_full_backpressure();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
